// File: rtl/seconds_counter_pkg.sv
// Shared widths, limits and the count-step decode used by the seconds counter.
`timescale 1ns/1ps
package seconds_counter_pkg;

  localparam int SEC_W               = 6;
  localparam int SEC_MODULUS_DEFAULT = 60;
  localparam int SEC_MAX             = SEC_MODULUS_DEFAULT - 1;

  typedef enum logic [2:0] {
    ACT_HOLD    = 3'd0,
    ACT_INC     = 3'd1,
    ACT_WRAP    = 3'd2,
    ACT_RECOVER = 3'd3,
    ACT_CLEAR   = 3'd4
  } count_action_e;

endpackage

// File: rtl/mod_n_counter.sv
// Generic modulo-N wrap counter with a combinational wrap strobe.
// The optional synchronous clear exists only under SECONDS_COUNTER_CLEAR_EN.
`timescale 1ns/1ps
module mod_n_counter
  import seconds_counter_pkg::*;
#(
  parameter int WIDTH   = SEC_W,
  parameter int MODULUS = SEC_MODULUS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
`ifdef SECONDS_COUNTER_CLEAR_EN
  input  logic             clear,
`endif
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;
  count_action_e    action;

  // An out-of-range value (e.g. after an upset) is recovered to 0 with no wrap.
  always_comb begin
    action  = ACT_HOLD;
    count_d = count_q;
`ifdef SECONDS_COUNTER_CLEAR_EN
    if (clear) begin
      action = ACT_CLEAR;
    end else
`endif
    if (enable) begin
      if (count_q == MAX_COUNT) begin
        action = ACT_WRAP;
      end else if (count_q > MAX_COUNT) begin
        action = ACT_RECOVER;
      end else begin
        action = ACT_INC;
      end
    end

    case (action)
      ACT_INC:     count_d = count_q + WIDTH'(1);
      ACT_WRAP:    count_d = '0;
      ACT_RECOVER: count_d = '0;
      ACT_CLEAR:   count_d = '0;
      default:     count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign wrap  = (action == ACT_WRAP);

endmodule

// File: rtl/seconds_counter.sv
// Seconds counter: modulo-MODULUS count with a registered one-cycle minute tick.
// Optional synchronous clear port enabled by defining SECONDS_COUNTER_CLEAR_EN.
`timescale 1ns/1ps
module seconds_counter
  import seconds_counter_pkg::*;
#(
  parameter int MODULUS = SEC_MODULUS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
`ifdef SECONDS_COUNTER_CLEAR_EN
  input  logic             clear,
`endif
  output logic [SEC_W-1:0] seconds,
  output logic             tick_minute
);

  logic wrap;
  logic tick_minute_d;
  logic tick_minute_q;

  mod_n_counter #(
    .WIDTH   (SEC_W),
    .MODULUS (MODULUS)
  ) u_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
`ifdef SECONDS_COUNTER_CLEAR_EN
    .clear  (clear),
`endif
    .count  (seconds),
    .wrap   (wrap)
  );

  // The tick is registered alongside the count so it lines up with seconds == 0.
  always_comb begin
    tick_minute_d = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_minute_q <= 1'b0;
    end else begin
      tick_minute_q <= tick_minute_d;
    end
  end

  assign tick_minute = tick_minute_q;

endmodule

// File: tb/tb_seconds_counter.sv
// Randomized self-checking bench for seconds_counter against a simple arithmetic model.
`timescale 1ns/1ps
module tb_seconds_counter;
   import seconds_counter_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             enable;
`ifdef SECONDS_COUNTER_CLEAR_EN
   logic             clear;
`endif
   logic [SEC_W-1:0] seconds;
   logic             tick_minute;

   int vecCount = 0;
   int errCount = 0;
   int expSec   = 0;
   int expTick  = 0;

   seconds_counter #(
      .MODULUS (SEC_MODULUS_DEFAULT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
`ifdef SECONDS_COUNTER_CLEAR_EN
      .clear       (clear),
`endif
      .seconds     (seconds),
      .tick_minute (tick_minute)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Compare one observed value with the model and report any difference
   task automatic checkOutput(input string tag, input integer observed, input integer expected);
      vecCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // Reference behaviour of one rising edge, written from the counting rules
   task automatic modelEdge(input bit en, input bit clr);
      if (clr) begin
         expSec  = 0;
         expTick = 0;
      end else if (en) begin
         if (expSec == SEC_MAX) begin
            expSec  = 0;
            expTick = 1;
         end else if (expSec > SEC_MAX) begin
            expSec  = 0;
            expTick = 0;
         end else begin
            expSec  = expSec + 1;
            expTick = 0;
         end
      end else begin
         expTick = 0;
      end
   endtask

   // Drive inputs, take one edge, then sample outputs 1 ns after it
   task automatic applyStimulus(input bit en, input bit clr);
      enable = en;
`ifdef SECONDS_COUNTER_CLEAR_EN
      clear = clr;
`endif
      @(posedge clk);
`ifdef SECONDS_COUNTER_CLEAR_EN
      modelEdge(en, clr);
`else
      modelEdge(en, 1'b0);
`endif
      #1;
      checkOutput("seconds", seconds, expSec);
      checkOutput("tick_minute", tick_minute, expTick);
   endtask

   // Asynchronous reset pulse placed between edges; checks it bites at once
   task automatic asyncReset(input int preDelay, input int holdDelay);
      #(preDelay);
      rst_n = 1'b0;
      expSec  = 0;
      expTick = 0;
      #1;
      checkOutput("reset_seconds", seconds, 0);
      checkOutput("reset_tick", tick_minute, 0);
      #(holdDelay);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n  = 1'b0;
      enable = 1'b0;
`ifdef SECONDS_COUNTER_CLEAR_EN
      clear  = 1'b0;
`endif
      #12;
      checkOutput("por_seconds", seconds, 0);
      checkOutput("por_tick", tick_minute, 0);
      rst_n = 1'b1;

      // Full minute: 0..59 then wrap with a single tick, then tick drops
      $display("[TB] full minute run");
      for (int i = 0; i < 60; i++) applyStimulus(1'b1, 1'b0);
      checkOutput("wrap_seconds", seconds, 0);
      checkOutput("wrap_tick", tick_minute, 1);
      applyStimulus(1'b0, 1'b0);

      // Alternating enable for 20 cycles from zero
      $display("[TB] toggled enable");
      asyncReset(2, 2);
      for (int i = 0; i < 20; i++) applyStimulus((i % 2) == 0, 1'b0);
      checkOutput("toggle_seconds", seconds, 10);

      // Mid-count async reset for 10 ns at seconds=37
      $display("[TB] async reset at 37");
      asyncReset(2, 2);
      for (int i = 0; i < 37; i++) applyStimulus(1'b1, 1'b0);
      checkOutput("pre_reset_seconds", seconds, 37);
      asyncReset(2, 9);
      applyStimulus(1'b1, 1'b0);
      checkOutput("post_reset_seconds", seconds, 1);

      // Hold at 59 for 5 disabled cycles, then wrap, then the pulse ends
      $display("[TB] hold at 59");
      asyncReset(2, 2);
      for (int i = 0; i < 59; i++) applyStimulus(1'b1, 1'b0);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0);
      checkOutput("hold_seconds", seconds, 59);
      applyStimulus(1'b1, 1'b0);
      checkOutput("hold_wrap_tick", tick_minute, 1);
      applyStimulus(1'b0, 1'b0);
      checkOutput("hold_tick_drop", tick_minute, 0);

`ifdef SECONDS_COUNTER_CLEAR_EN
      // Clear at 59 with enable wins and does not tick
      $display("[TB] clear at 59");
      asyncReset(2, 2);
      for (int i = 0; i < 59; i++) applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1);
      checkOutput("clear_seconds", seconds, 0);
      checkOutput("clear_tick", tick_minute, 0);
`endif

      // Random enable (and clear when present) over several minutes
      $display("[TB] random enable run");
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 47) == 0);
      end

      // Random async reset pulses with enable held high
      $display("[TB] random reset pulses");
      for (int it = 0; it < 10; it++) begin
         int gapNs;
         gapNs = $urandom_range(20, 119);
         for (int c = 0; c < gapNs / 10; c++) applyStimulus(1'b1, 1'b0);
         asyncReset($urandom_range(1, 3), $urandom_range(1, 2));
      end
      for (int i = 0; i < 70; i++) applyStimulus(1'b1, 1'b0);

      $display("[TB] == %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule

// File: doc/seconds_counter.md
SECONDS_COUNTER -- requirements
Module: seconds_counter

Interface
REQ-001 Parameter: MODULUS, default 60, count modulus; legal range 2..64.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 Port: enable  input  1  count-advance qualifier, sampled on rising clk.
REQ-005 Port: seconds  output  6  current count, registered, unsigned.
REQ-006 Port: tick_minute  output  1  registered one-cycle wrap pulse.
REQ-007 Port (only with SECONDS_COUNTER_CLEAR_EN): clear  input  1  synchronous clear request.

Function
REQ-008 On a rising clk with enable=1 and seconds<MODULUS-1, seconds SHALL increment by 1.
REQ-009 On a rising clk with enable=1 and seconds=MODULUS-1, seconds SHALL wrap to 0.
REQ-010 With enable=0, seconds and the internal state SHALL hold.
REQ-011 tick_minute SHALL be 1 for exactly the one cycle in which seconds has just wrapped to 0, and 0 otherwise.
- A wrap is the edge that loads 0 from MODULUS-1 with enable=1.
- tick_minute is never combinational from enable.
REQ-012 With enable held low after a wrap, tick_minute SHALL still deassert on the next rising edge.
- The pulse never stretches.
REQ-013 Latency: enable to a seconds change is one clock edge.
REQ-014 Arithmetic SHALL be 6-bit unsigned.
- The next-state logic never produces a value >= MODULUS.
REQ-015 If seconds ever holds a value >= MODULUS (for example after an upset), the next enabled edge SHALL load 0 without asserting tick_minute.

Reset
REQ-016 rst_n=0 SHALL immediately force seconds=0 and tick_minute=0, regardless of clk.
REQ-017 Reset SHALL override enable and clear at all times, including mid-count and on the wrap cycle.
REQ-018 After rst_n deasserts, counting SHALL resume from 0 on the first rising edge with enable=1.
- Deassertion is assumed synchronised externally.

Configuration
REQ-019 Macro SECONDS_COUNTER_CLEAR_EN, when defined, SHALL add the clear port.
- On a rising clk with clear=1: seconds=0 and tick_minute=0.
- clear has priority over enable.
- clear never generates a tick.
REQ-020 Without SECONDS_COUNTER_CLEAR_EN, the clear port and its logic SHALL be absent.
- Behaviour is otherwise identical.

Structure
REQ-021 Shared package seconds_counter_pkg SHALL hold:
- SEC_W = 6;
- SEC_MODULUS_DEFAULT = 60;
- SEC_MAX = 59.
REQ-022 One sub-module, mod_n_counter, SHALL implement the generic wrap counter.
- Parameters: width and modulus.
- Outputs: count and wrap strobe.
- seconds_counter wraps it and registers tick_minute.

Verification
REQ-023 Reset then enable=1 for 60 cycles -> seconds steps 0..59, returns to 0 on edge 60, and tick_minute=1 only in that cycle.
REQ-024 Enable toggled 1/0 each cycle for 20 cycles -> seconds reaches 10, and tick_minute stays 0.
REQ-025 Async reset asserted for 10 ns at seconds=37, between clock edges -> seconds=0 immediately; after release, the next enabled edge gives 1.
REQ-026 Random reset pulses every 20..119 ns over 10 iterations with enable=1 -> seconds never exceeds 59, and tick_minute appears only on 59->0.
REQ-027 At seconds=59, drop enable for 5 cycles then raise it -> seconds holds 59, then wraps to 0 with a single tick.
REQ-028 With SECONDS_COUNTER_CLEAR_EN, clear=1 at seconds=59 with enable=1 -> seconds=0, and tick_minute=0.
